// File: rtl/fb_capture_if.sv
// Pixel-write and RGB stream bundle for fb_capture.
// The master drives GPU writes and consumer ready; the slave (fb_capture) drives the stream.
interface fb_capture_if #(
    parameter int ADDR_W = 19
);
    logic [ADDR_W-1:0] addr;
    logic              wen;
    logic [7:0]        dout;
    logic              done;
    logic [7:0]        px_r;
    logic [7:0]        px_g;
    logic [7:0]        px_b;
    logic              px_valid;
    logic              px_ready;
    logic              px_sof;
    logic              px_eol;
    logic              px_eof;
    logic              busy;
    logic              wr_err;

    modport master (
        output addr, wen, dout, done, px_ready,
        input  px_r, px_g, px_b, px_valid, px_sof, px_eol, px_eof, busy, wr_err
    );

    modport slave (
        input  addr, wen, dout, done, px_ready,
        output px_r, px_g, px_b, px_valid, px_sof, px_eol, px_eof, busy, wr_err
    );
endinterface

// File: rtl/fb_capture.sv
// Framebuffer capture: stores RGB332 writes, dumps the frame as RGB888 on a done rising edge.
// Define FB_CAPTURE_CLEAR_EN to zero the whole RAM after reset before capture starts.
module fb_capture #(
    parameter int WIDTH  = 640,
    parameter int HEIGHT = 480,
    parameter int ADDR_W = 19
) (
    input logic        clk,
    input logic        reset,
    fb_capture_if.slave bus
);
    localparam int NPIX = WIDTH * HEIGHT;
    localparam int XW   = (WIDTH > 1)  ? $clog2(WIDTH)  : 1;
    localparam int YW   = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

    localparam logic [1:0] ST_CAPTURE = 2'd0;
    localparam logic [1:0] ST_CLEAR   = 2'd1;
    localparam logic [1:0] ST_DUMP    = 2'd2;

`ifdef FB_CAPTURE_CLEAR_EN
    localparam logic [1:0] ST_RESET = ST_CLEAR;
`else
    localparam logic [1:0] ST_RESET = ST_CAPTURE;
`endif

    localparam logic [ADDR_W:0]   NPIX_W    = (ADDR_W + 1)'(NPIX);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NPIX - 1);
    localparam logic [XW-1:0]     LAST_X    = XW'(WIDTH - 1);
    localparam logic [YW-1:0]     LAST_Y    = YW'(HEIGHT - 1);

    logic [7:0] mem [NPIX];

    logic [1:0]        state_q, state_d;
    logic              done_q;
    logic              wrErr_q;
    logic [ADDR_W-1:0] clrPtr_q;
    logic [ADDR_W-1:0] rdPtr_q;
    logic [XW-1:0]     x_q;
    logic [YW-1:0]     y_q;
    logic              issuedAll_q;
    logic              rdVld_q;
    logic [7:0]        rdPix_q;
    logic              rdSof_q, rdEol_q, rdEof_q;
    logic              outVld_q, skidVld_q;
    logic [10:0]       outBeat_q, skidBeat_q;

    logic              inRange;
    logic              doneRise;
    logic              fire;
    logic              eofFire;
    logic              issue;
    logic [1:0]        storedAfter;
    logic [10:0]       rdBeat;
    logic              memWe;
    logic [ADDR_W-1:0] memWaddr;
    logic [7:0]        memWdata;

    assign inRange  = {1'b0, bus.addr} < NPIX_W;
    assign doneRise = bus.done & ~done_q;
    assign fire     = outVld_q & bus.px_ready;
    assign eofFire  = fire & outBeat_q[0];
    assign rdBeat   = {rdPix_q, rdSof_q, rdEol_q, rdEof_q};

    // A read may only be issued if, after this edge, at most one beat is held,
    // so the returning RAM word is guaranteed a slot in the output register or skid.
    assign storedAfter = 2'(outVld_q) + 2'(skidVld_q) + 2'(rdVld_q) - 2'(fire);
    assign issue       = (state_q == ST_DUMP) && !issuedAll_q && (storedAfter <= 2'd1);

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_CLEAR:   if (clrPtr_q == LAST_ADDR) state_d = ST_CAPTURE;
            ST_CAPTURE: if (doneRise) state_d = ST_DUMP;
            ST_DUMP:    if (eofFire) state_d = ST_CAPTURE;
            default:    state_d = ST_CAPTURE;
        endcase
    end

    always_comb begin
        memWe    = 1'b0;
        memWaddr = bus.addr;
        memWdata = bus.dout;
        if (state_q == ST_CLEAR) begin
            memWe    = 1'b1;
            memWaddr = clrPtr_q;
            memWdata = 8'h00;
        end else if (state_q == ST_CAPTURE && bus.wen && inRange) begin
            memWe = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (memWe) mem[memWaddr] <= memWdata;
    end

    always_ff @(posedge clk) begin
        if (issue) rdPix_q <= mem[rdPtr_q];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_RESET;
            done_q      <= 1'b0;
            wrErr_q     <= 1'b0;
            clrPtr_q    <= '0;
            rdPtr_q     <= '0;
            x_q         <= '0;
            y_q         <= '0;
            issuedAll_q <= 1'b0;
            rdVld_q     <= 1'b0;
            rdSof_q     <= 1'b0;
            rdEol_q     <= 1'b0;
            rdEof_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= bus.done;
            if (bus.wen && (state_q != ST_CAPTURE || !inRange)) wrErr_q <= 1'b1;
            if (state_q == ST_CLEAR) clrPtr_q <= clrPtr_q + 1'b1;

            rdVld_q <= issue;
            if (issue) begin
                rdPtr_q <= rdPtr_q + 1'b1;
                rdSof_q <= (x_q == '0) && (y_q == '0);
                rdEol_q <= (x_q == LAST_X);
                rdEof_q <= (x_q == LAST_X) && (y_q == LAST_Y);
                if (x_q == LAST_X) begin
                    x_q <= '0;
                    y_q <= y_q + 1'b1;
                    if (y_q == LAST_Y) issuedAll_q <= 1'b1;
                end else begin
                    x_q <= x_q + 1'b1;
                end
            end

            if (eofFire) begin
                rdPtr_q     <= '0;
                x_q         <= '0;
                y_q         <= '0;
                issuedAll_q <= 1'b0;
            end
        end
    end

    // Output register refills from the skid first so beats stay in raster order.
    always_ff @(posedge clk) begin
        if (reset) begin
            outVld_q   <= 1'b0;
            skidVld_q  <= 1'b0;
            outBeat_q  <= '0;
            skidBeat_q <= '0;
        end else if (!outVld_q || fire) begin
            if (skidVld_q) begin
                outBeat_q <= skidBeat_q;
                outVld_q  <= 1'b1;
                skidVld_q <= rdVld_q;
                if (rdVld_q) skidBeat_q <= rdBeat;
            end else if (rdVld_q) begin
                outBeat_q <= rdBeat;
                outVld_q  <= 1'b1;
            end else begin
                outVld_q <= 1'b0;
            end
        end else if (rdVld_q) begin
            skidBeat_q <= rdBeat;
            skidVld_q  <= 1'b1;
        end
    end

    logic [2:0] outR, outG;
    logic [1:0] outB;

    assign outR = outBeat_q[10:8];
    assign outG = outBeat_q[7:5];
    assign outB = outBeat_q[4:3];

    assign bus.px_r     = {outR, outR, outR[2:1]};
    assign bus.px_g     = {outG, outG, outG[2:1]};
    assign bus.px_b     = {outB, outB, outB, outB};
    assign bus.px_valid = outVld_q;
    assign bus.px_sof   = outBeat_q[2];
    assign bus.px_eol   = outBeat_q[1];
    assign bus.px_eof   = outBeat_q[0];
    assign bus.busy     = (state_q != ST_CAPTURE);
    assign bus.wr_err   = wrErr_q;
endmodule

// File: tb/tb_fb_capture.sv
// Scoreboard bench for fb_capture: a 4x3 instance under random backpressure and
// a 640x4 instance exercising line/frame boundaries with ready held high.
`timescale 1ns/1ps
module tb_fb_capture;
    localparam int SW = 4;
    localparam int SH = 3;
    localparam int SA = 4;
    localparam int SN = SW * SH;
    localparam int WW = 640;
    localparam int WH = 4;
    localparam int WA = 12;
    localparam int WN = WW * WH;
`ifdef FB_CAPTURE_CLEAR_EN
    localparam int EXP_CLEAR = SN;
`else
    localparam int EXP_CLEAR = 0;
`endif

    logic clk = 1'b0;
    logic sReset, wReset;
    logic sRandReady;

    always #5 clk = ~clk;

    fb_capture_if #(.ADDR_W(SA)) sIf ();
    fb_capture_if #(.ADDR_W(WA)) wIf ();

    fb_capture #(.WIDTH(SW), .HEIGHT(SH), .ADDR_W(SA)) sDut (
        .clk   (clk),
        .reset (sReset),
        .bus   (sIf)
    );

    fb_capture #(.WIDTH(WW), .HEIGHT(WH), .ADDR_W(WA)) wDut (
        .clk   (clk),
        .reset (wReset),
        .bus   (wIf)
    );

    int compareCount  = 0;
    int mismatchCount = 0;

    logic [7:0]  sModel [SN];
    logic [7:0]  wModel [WN];
    logic [26:0] sQ [$];
    logic [26:0] wQ [$];
    int          sBeats = 0;
    int          wBeats = 0;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compareCount++;
        if (observed !== expected) begin
            mismatchCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    function automatic logic [23:0] expandRgb(input logic [7:0] p);
        logic [2:0] r, g;
        logic [1:0] b;
        r = p[7:5];
        g = p[4:2];
        b = p[1:0];
        return {r, r, r[2:1], g, g, g[2:1], b, b, b, b};
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Caller is aligned just after a rising edge; the write occupies one cycle.
    task automatic applyStimulus(input bit wide, input int a, input logic [7:0] d);
        if (wide) begin
            wIf.addr = WA'(a);
            wIf.dout = d;
            wIf.wen  = 1'b1;
        end else begin
            sIf.addr = SA'(a);
            sIf.dout = d;
            sIf.wen  = 1'b1;
        end
        tick(1);
        sIf.wen = 1'b0;
        wIf.wen = 1'b0;
    endtask

    task automatic startDump(input bit wide);
        if (wide) begin
            for (int i = 0; i < WN; i++)
                wQ.push_back({expandRgb(wModel[i]), 1'(i == 0), 1'((i % WW) == WW - 1), 1'(i == WN - 1)});
            wIf.done = 1'b1;
        end else begin
            for (int i = 0; i < SN; i++)
                sQ.push_back({expandRgb(sModel[i]), 1'(i == 0), 1'((i % SW) == SW - 1), 1'(i == SN - 1)});
            sIf.done = 1'b1;
        end
    endtask

    task automatic checkLatency(input bit wide);
        int n;
        @(posedge clk);
        #1;
        sIf.wen = 1'b0;
        wIf.wen = 1'b0;
        @(negedge clk);
        checkOutput(wide ? "wide valid right after edge" : "small valid right after edge",
                    32'(wide ? wIf.px_valid : sIf.px_valid), 32'd0);
        n = 0;
        repeat (20) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (wide ? wIf.px_valid : sIf.px_valid) break;
        end
        checkOutput(wide ? "wide first valid latency" : "small first valid latency", 32'(n), 32'd2);
    endtask

    task automatic waitIdle(input bit wide, input int budget);
        repeat (budget) begin
            @(negedge clk);
            if (wide ? (!wIf.busy && wQ.size() == 0) : (!sIf.busy && sQ.size() == 0)) break;
        end
        checkOutput(wide ? "wide idle busy" : "small idle busy", 32'(wide ? wIf.busy : sIf.busy), 32'd0);
        checkOutput(wide ? "wide idle queue" : "small idle queue",
                    32'(wide ? wQ.size() : sQ.size()), 32'd0);
    endtask

    always @(posedge clk) begin
        #1 sIf.px_ready = sRandReady ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Small-instance monitor: scoreboard pops plus hold-stability under backpressure.
    logic [26:0] sPrev;
    logic        sPrevHold = 1'b0;
    always @(negedge clk) begin
        logic [26:0] obs;
        logic [26:0] exp;
        obs = {sIf.px_r, sIf.px_g, sIf.px_b, sIf.px_sof, sIf.px_eol, sIf.px_eof};
        if (sReset) begin
            sPrevHold = 1'b0;
        end else begin
            if (sPrevHold) begin
                checkOutput("small hold valid", 32'(sIf.px_valid), 32'd1);
                checkOutput("small hold data", 32'(obs), 32'(sPrev));
            end
            if (sIf.px_valid && sIf.px_ready) begin
                if (sQ.size() == 0) begin
                    checkOutput("small beat with empty scoreboard", 32'(sQ.size()), 32'd1);
                end else begin
                    exp = sQ.pop_front();
                    checkOutput($sformatf("small beat %0d", sBeats), 32'(obs), 32'(exp));
                end
                sBeats++;
            end
            sPrevHold = sIf.px_valid && !sIf.px_ready;
            sPrev     = obs;
        end
    end

    always @(negedge clk) begin
        logic [26:0] obs;
        logic [26:0] exp;
        obs = {wIf.px_r, wIf.px_g, wIf.px_b, wIf.px_sof, wIf.px_eol, wIf.px_eof};
        if (!wReset && wIf.px_valid && wIf.px_ready) begin
            if (wQ.size() == 0) begin
                checkOutput("wide beat with empty scoreboard", 32'(wQ.size()), 32'd1);
            end else begin
                exp = wQ.pop_front();
                checkOutput($sformatf("wide beat %0d", wBeats), 32'(obs), 32'(exp));
            end
            wBeats++;
        end
    end

    initial begin
        #5ms;
        $display("[TB] FAIL watchdog: simulation time limit reached, got timeout, expected finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int busyCycles;
        int base;
        int cnt;

        sReset = 1'b1;
        wReset = 1'b1;
        sRandReady = 1'b0;
        sIf.wen = 1'b0; sIf.addr = '0; sIf.dout = '0; sIf.done = 1'b0;
        wIf.wen = 1'b0; wIf.addr = '0; wIf.dout = '0; wIf.done = 1'b0;
        wIf.px_ready = 1'b1;
        tick(3);

        @(negedge clk);
        checkOutput("small reset outputs",
                    32'({sIf.px_r, sIf.px_g, sIf.px_b, sIf.px_valid, sIf.px_sof, sIf.px_eol, sIf.px_eof, sIf.wr_err}), 32'd0);
        checkOutput("wide reset outputs",
                    32'({wIf.px_r, wIf.px_g, wIf.px_b, wIf.px_valid, wIf.px_sof, wIf.px_eol, wIf.px_eof, wIf.wr_err}), 32'd0);
`ifndef FB_CAPTURE_CLEAR_EN
        checkOutput("small reset busy", 32'(sIf.busy), 32'd0);
`endif
        @(posedge clk);
        #1;
        sReset = 1'b0;
        wReset = 1'b0;
        busyCycles = 0;
        repeat (SN + 20) begin
            @(negedge clk);
            if (sIf.busy) busyCycles++;
            else break;
        end
        checkOutput("small busy cycles after reset", 32'(busyCycles), 32'(EXP_CLEAR));
        waitIdle(1, WN + 100);

        // Fill with mem[i]=i; address 3 is written twice back to back, the second must win.
        tick(1);
        for (int i = 0; i < SN; i++) begin
            if (i == 3) applyStimulus(0, 3, 8'h11);
            applyStimulus(0, i, 8'(i));
            sModel[i] = 8'(i);
        end

        // Dump 1: write to address 7 in the same cycle as the done edge, then keep done high.
        sRandReady = 1'b1;
        sIf.addr = SA'(7);
        sIf.dout = 8'h5A;
        sIf.wen  = 1'b1;
        sModel[7] = 8'h5A;
        startDump(0);
        checkLatency(0);
        waitIdle(0, 500);
        repeat (20) @(negedge clk);
        checkOutput("small no retrigger busy", 32'(sIf.busy), 32'd0);
        checkOutput("small beats after dump 1", 32'(sBeats), 32'(SN));
        checkOutput("small wr_err before errors", 32'(sIf.wr_err), 32'd0);

        // Dump 2: fresh edge, identical contents; a write during DUMP must be dropped.
        tick(1);
        sIf.done = 1'b0;
        tick(2);
        startDump(0);
        checkLatency(0);
        tick(1);
        applyStimulus(0, 2, 8'hFF);
        waitIdle(0, 500);
        checkOutput("small wr_err after write in dump", 32'(sIf.wr_err), 32'd1);
        checkOutput("small beats after dump 2", 32'(sBeats), 32'(2 * SN));

        // Dump 3: reset at beat 5 aborts the stream.
        tick(1);
        sIf.done = 1'b0;
        tick(2);
        startDump(0);
        checkLatency(0);
        base = sBeats;
        repeat (500) begin
            @(negedge clk);
            if (sBeats >= base + 5) break;
        end
        checkOutput("small reached beat 5", 32'(sBeats - base), 32'd5);
        @(posedge clk);
        #1;
        sReset   = 1'b1;
        sIf.done = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checkOutput("small valid after mid-dump reset", 32'(sIf.px_valid), 32'd0);
        checkOutput("small wr_err after reset", 32'(sIf.wr_err), 32'd0);
        @(posedge clk);
        #1;
        sReset = 1'b0;
        sQ.delete();
        waitIdle(0, SN + 50);

        // Rewrite, then an out-of-range write that must not touch RAM.
        tick(1);
        for (int i = 0; i < SN; i++) begin
            applyStimulus(0, i, 8'(i * 37 + 5));
            sModel[i] = 8'(i * 37 + 5);
        end
        applyStimulus(0, SN, 8'hAA);
        checkOutput("small wr_err out of range", 32'(sIf.wr_err), 32'd1);
        base = sBeats;
        startDump(0);
        checkLatency(0);
        waitIdle(0, 500);
        checkOutput("small beats after restart dump", 32'(sBeats - base), 32'(SN));
        sRandReady = 1'b0;

        // Wide instance: line boundary at 639/640 and end-of-frame, ready held high.
        tick(1);
        sIf.done = 1'b0;
        for (int i = 0; i < WN; i++) begin
            applyStimulus(1, i, 8'(i * 7));
            wModel[i] = 8'(i * 7);
        end
        applyStimulus(1, 0, 8'hE0);
        wModel[0] = 8'hE0;
        applyStimulus(1, WW - 1, 8'h1C);
        wModel[WW - 1] = 8'h1C;
        applyStimulus(1, WW, 8'h03);
        wModel[WW] = 8'h03;
        startDump(1);
        checkLatency(1);
        cnt = 1;
        repeat (WN + 10) begin
            @(negedge clk);
            if (wIf.px_valid) cnt++;
            else break;
        end
        checkOutput("wide consecutive valid beats", 32'(cnt), 32'(WN));
        checkOutput("wide busy after eof", 32'(wIf.busy), 32'd0);
        waitIdle(1, 100);
        checkOutput("wide beats total", 32'(wBeats), 32'(WN));
        tick(1);
        wIf.done = 1'b0;
        applyStimulus(1, WN, 8'h55);
        checkOutput("wide wr_err out of range", 32'(wIf.wr_err), 32'd1);

        tick(5);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end
endmodule

// File: doc/fb_capture.md
Name: fb_capture

Overview:
- Synthesizable, parametrised framebuffer capture and dump block, sitting on the GPU pixel-write port (addr/wen/dout/done).
- Stores RGB332 pixel writes into internal RAM.
- On a rising edge of done, streams the frame out in raster order as 8-bit-per-channel RGB with valid/ready, SOF/EOL/EOF markers.
- The stream feeds a UART/host dumper or a bench PPM writer.

Parameters:
- WIDTH, 640, pixels per line.
- HEIGHT, 480, lines per frame.
- ADDR_W, 19, pixel address width; must satisfy 2**ADDR_W >= WIDTH*HEIGHT.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- addr  in  ADDR_W  pixel write address, linear: y*WIDTH+x.
- wen  in  1  pixel write enable.
- dout  in  8  pixel data, RGB332: [7:5] R, [4:2] G, [1:0] B.
- done  in  1  GPU frame-complete level; its rising edge starts the dump.
- px_r  out  8  expanded red.
- px_g  out  8  expanded green.
- px_b  out  8  expanded blue.
- px_valid  out  1  output pixel valid.
- px_ready  in  1  consumer ready.
- px_sof  out  1  first pixel of frame (x=0, y=0), qualified by px_valid.
- px_eol  out  1  last pixel of line (x=WIDTH-1), qualified by px_valid.
- px_eof  out  1  last pixel of frame, qualified by px_valid.
- busy  out  1  high in CLEAR or DUMP.
- wr_err  out  1  sticky; set by an out-of-range write, or by a write while busy.

Behaviour:
- Reset: all outputs 0. State goes to CLEAR if FB_CAPTURE_CLEAR_EN is defined, else CAPTURE. done edge detector is cleared, with the previous value of done taken as 0.
- States:
  - CLEAR -> CAPTURE after the last address is written.
  - CAPTURE -> DUMP on a done rising edge.
  - DUMP -> CAPTURE after the EOF beat handshakes.
- CAPTURE:
  - wen=1 with addr < WIDTH*HEIGHT: mem[addr] <= dout at the clk edge.
  - Two writes to the same address in consecutive cycles: the last one wins.
  - addr >= WIDTH*HEIGHT: write dropped, wr_err set.
- done rising edge with wen in the same cycle: the write is committed first, then DUMP is entered. The dump therefore includes that write.
- DUMP:
  - Read pointer runs 0..WIDTH*HEIGHT-1; RAM read latency is 1 cycle.
  - Output register plus one-entry skid.
  - First px_valid is asserted exactly 2 cycles after the cycle in which the done edge is sampled.
  - A beat transfers when px_valid && px_ready.
  - While px_valid && !px_ready: px_r/g/b/sof/eol/eof are held stable, and px_valid does not drop.
  - With px_ready held high: one pixel per cycle, no bubbles.
- Expansion by bit replication:
  - R8 = {R,R,R[2:1]}.
  - G8 = {G,G,G[2:1]}.
  - B8 = {B,B,B,B}.
- Markers:
  - px_sof on pointer 0.
  - px_eol when x == WIDTH-1, where x and y are separate counters (no division).
  - px_eof on pointer WIDTH*HEIGHT-1; that beat also has px_eol=1.
- After the EOF handshake:
  - px_valid=0 next cycle.
  - busy falls the same cycle.
  - Returns to CAPTURE.
  - Memory contents are retained; not cleared.
- Writes (wen=1) during DUMP or CLEAR are dropped and set wr_err.
- done edges during DUMP/CLEAR are ignored. A new dump needs a fresh rising edge after returning to CAPTURE; a level held high does not retrigger.
- Reset mid-DUMP: stream aborts, px_valid=0 next cycle, pointers zeroed, RAM contents not guaranteed.
- wr_err is cleared only by reset.

Optional Feature:
- Macro: FB_CAPTURE_CLEAR_EN.
- Defined:
  - After reset, CLEAR writes 0x00 to every address, one per cycle, for WIDTH*HEIGHT cycles, with busy=1.
  - CAPTURE is entered on the following cycle.
- Not defined:
  - No clear sweep; RAM powers up undefined.
  - busy=0 immediately after reset, and CAPTURE is entered directly.

Test Plan:
- Reset, with WIDTH=4, HEIGHT=3: all outputs 0 and wr_err=0. With CLEAR_EN, busy=1 for exactly 12 cycles, then 0.
- Defaults, px_ready=1:
  - Stimulus: write addr0=0xE0, addr639=0x1C, addr640=0x03; pulse done.
  - First beat 2 cycles after the edge: (FF,00,00) with sof=1.
  - Beat 639: (00,FF,00) with eol=1.
  - Beat 640: (00,00,FF) with sof=0.
  - Beat 307199 has eof=1 and eol=1; busy drops after it.
- Backpressure, WIDTH=4, HEIGHT=3, mem[i]=i:
  - Stimulus: toggle px_ready randomly.
  - 12 beats received, in order 0..11; expanded values match the replication rule.
  - Data is stable whenever px_valid && !px_ready; no beats lost or duplicated.
- Error path:
  - Write addr=307200 in CAPTURE -> wr_err=1, no RAM change.
  - Write during DUMP -> dropped; the dumped value at that address is unchanged.
- Done handling:
  - done held high after dump completes -> no second dump.
  - Drop and re-raise done -> second dump with identical contents.
  - Write plus done edge in the same cycle -> the write is visible in the dump.
- Reset asserted mid-DUMP at beat 5 -> px_valid=0 next cycle. A following done edge restarts from sof at pointer 0.
